// File: rtl/divisor_punto_fijo.sv
// divisor_punto_fijo: sequential signed fixed-point divider.
// Restoring division on operand magnitudes, one quotient bit per clock,
// with start/done handshake and multiplier-compatible saturation.
module divisor_punto_fijo #(
    parameter int unsigned Decimal  = 16,
    parameter int unsigned Magnitud = 8,
    parameter int unsigned N        = Decimal + Magnitud + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Division,
    output logic         div_cero
);

    localparam int unsigned ITER = N + Decimal;
    localparam int unsigned CW   = $clog2(ITER);
    localparam logic [N-1:0]    MAXIMO     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]    MINIMO     = {1'b1, {(N-2){1'b0}}, 1'b1};
    localparam logic [ITER-1:0] MAXIMO_EXT = {{Decimal{1'b0}}, MAXIMO};
    localparam logic [CW-1:0]   LAST_ITER  = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Remainder is always < |B| <= 2^(N-1), so N bits hold it between
    // iterations; the shifted trial value needs N+1 bits.
    logic [N-1:0]    rem_q, rem_d;
    // Holds the shifted dividend at start; quotient bits enter at the LSB
    // as dividend bits leave at the MSB.
    logic [ITER-1:0] quo_q, quo_d;
    logic [N-1:0]    abs_b_q, abs_b_d;
    logic            sign_q, sign_d;
    logic            zero_q, zero_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    division_q, division_d;
    logic            div_cero_q, div_cero_d;

    logic [N-1:0]    a_abs;
    logic [N-1:0]    b_abs;
    logic [N:0]      rem_shift;
    logic            q_bit;

    // Next-state, datapath and output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        abs_b_d    = abs_b_q;
        sign_d     = sign_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        division_d = division_q;
        div_cero_d = div_cero_q;

        a_abs     = A[N-1] ? ((~A) + N'(1)) : A;
        b_abs     = B[N-1] ? ((~B) + N'(1)) : B;
        rem_shift = {rem_q, quo_q[ITER-1]};
        q_bit     = (rem_shift >= {1'b0, abs_b_q});

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    abs_b_d = b_abs;
                    quo_d   = {a_abs, {Decimal{1'b0}}};
                    rem_d   = '0;
                    cnt_d   = '0;
                    sign_d  = A[N-1] ^ B[N-1];
                    zero_d  = (b_abs == '0);
                    busy_d  = 1'b1;
                    state_d = (b_abs == '0) ? DONE : CALC;
                end
            end

            CALC: begin
                rem_d = q_bit ? (rem_shift[N-1:0] - abs_b_q) : rem_shift[N-1:0];
                quo_d = {quo_q[ITER-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                div_cero_d = zero_q;
                if (zero_q || (quo_q > MAXIMO_EXT)) begin
                    // With B zero the sign reduces to A's sign bit
                    division_d = sign_q ? MINIMO : MAXIMO;
                end else if (sign_q) begin
                    division_d = (~quo_q[N-1:0]) + N'(1);
                end else begin
                    division_d = quo_q[N-1:0];
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            abs_b_q    <= '0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            division_q <= '0;
            div_cero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            abs_b_q    <= abs_b_d;
            sign_q     <= sign_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            division_q <= division_d;
            div_cero_q <= div_cero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Division = division_q;
    assign div_cero = div_cero_q;

endmodule

// File: tb/tb_divisor_punto_fijo.sv
// Directed testbench for divisor_punto_fijo (default Q8.16 format).
module tb_divisor_punto_fijo;

    localparam int unsigned N = 25;
    localparam int          LAT = 42;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Division;
    logic         div_cero;

    int n_cmp = 0;
    int n_err = 0;

    divisor_punto_fijo dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Division (Division),
        .div_cero (div_cero)
    );

    always #5 clk = ~clk;

    // Pulse start for one cycle; returns 1ns after the sampling edge t0.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (bounded).
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (Division !== 25'h0) begin n_err++; $display("FAIL reset_division got=%h exp=0", Division); end
        n_cmp++; if (div_cero !== 1'b0) begin n_err++; $display("FAIL reset_div_cero got=%b exp=0", div_cero); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_division;
        logic [N-1:0] va [5] = '{25'h0030000, 25'h1FD0000, 25'h0010000, 25'h0C80000, 25'h1380000};
        logic [N-1:0] vb [5] = '{25'h0020000, 25'h0020000, 25'h0030000, 25'h0000001, 25'h0000001};
        logic [N-1:0] vq [5] = '{25'h0018000, 25'h1FE8000, 25'h0005555, 25'h0FFFFFF, 25'h1000001};
        int lat;
        bit seen;
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i]);
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div%0d_busy got=%b exp=1", i, busy); end
            wait_done(lat, seen);
            n_cmp++; if (!seen || lat != LAT) begin n_err++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            n_cmp++; if (Division !== vq[i]) begin n_err++; $display("FAIL div%0d_value got=%h exp=%h", i, Division, vq[i]); end
            n_cmp++; if (div_cero !== 1'b0) begin n_err++; $display("FAIL div%0d_div_cero got=%b exp=0", i, div_cero); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div%0d_busy_at_done got=%b exp=0", i, busy); end
            @(posedge clk);
            #1;
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL div%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div_zero;
        logic [N-1:0] va [2] = '{25'h0010000, 25'h1FF0000};
        logic [N-1:0] vq [2] = '{25'h0FFFFFF, 25'h1000001};
        int lat;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            launch(va[i], 25'h0);
            lat  = 0;
            seen = done;
            if (!seen) wait_done(lat, seen);
            else lat = 0;
            // done sampled 1ns after t0 would be latency 0; expected at t0+1
            n_cmp++; if (!seen || lat != 1) begin n_err++; $display("FAIL dz%0d_latency got=%0d exp=1", i, lat); end
            n_cmp++; if (Division !== vq[i]) begin n_err++; $display("FAIL dz%0d_value got=%h exp=%h", i, Division, vq[i]); end
            n_cmp++; if (div_cero !== 1'b1) begin n_err++; $display("FAIL dz%0d_div_cero got=%b exp=1", i, div_cero); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignored_start;
        int dones = 0;
        int first = 0;
        logic [N-1:0] res = '0;
        launch(25'h0030000, 25'h0020000);
        for (int e = 1; e <= 120; e++) begin
            if (e == 10) begin
                A     = 25'h0040000;
                B     = 25'h0010000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dones++;
                if (first == 0) begin
                    first = e;
                    res   = Division;
                end
            end
        end
        n_cmp++; if (dones != 1) begin n_err++; $display("FAIL ignored_done_count got=%0d exp=1", dones); end
        n_cmp++; if (first != LAT) begin n_err++; $display("FAIL ignored_latency got=%0d exp=%0d", first, LAT); end
        n_cmp++; if (res !== 25'h0018000) begin n_err++; $display("FAIL ignored_value got=%h exp=0018000", res); end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit seen;
        launch(25'h0030000, 25'h0020000);
        wait_done(lat, seen);
        n_cmp++; if (!seen || Division !== 25'h0018000) begin n_err++; $display("FAIL b2b_first got=%h exp=0018000", Division); end
        launch(25'h0040000, 25'h0020000);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        wait_done(lat, seen);
        n_cmp++; if (!seen || lat != LAT) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (Division !== 25'h0020000) begin n_err++; $display("FAIL b2b_value got=%h exp=0020000", Division); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        int lat;
        bit seen;
        launch(25'h0030000, 25'h0020000);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (Division !== 25'h0) begin n_err++; $display("FAIL midrst_division got=%h exp=0", Division); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL midrst_spurious_done got=%0d exp=0", dones); end
        launch(25'h0040000, 25'h0020000);
        wait_done(lat, seen);
        n_cmp++; if (!seen || lat != LAT) begin n_err++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (Division !== 25'h0020000) begin n_err++; $display("FAIL midrst_value got=%h exp=0020000", Division); end
    endtask

    initial begin
        test_reset();
        test_division();
        test_div_zero();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
